// File: rtl/morse_letter_controller.sv
// morse_letter_controller
//   Collects dot/line pulses from the morse decoder into a letter code,
//   closes the letter after GAP_TICKS idle ticks and presents it on a
//   valid/ack handshake. Flags word gaps (WORD_TICKS idle ticks after an
//   emitted letter) and symbol overflow / symbols dropped while holding.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   tick_en           : one-cycle pulse per gap-timing unit
//   ld_dot, ld_line   : one-cycle symbol pulses (both high = line)
//   code_ack          : consumer accepts the presented letter
//   symbol_code       : letter bits, 1=line, first symbol in bit 0
//   symbol_len        : number of valid symbols in symbol_code
//   code_valid        : letter presented, held until code_ack
//   word_space        : one-cycle word-gap pulse
//   overflow_err      : one-cycle pulse on too many / dropped symbols
//   busy              : letter in progress, held or being discarded
module morse_letter_controller #(
  parameter int MAX_SYMBOLS = 5,
  parameter int GAP_TICKS   = 8,
  parameter int WORD_TICKS  = 20,
  parameter int CNT_W       = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick_en,
  input  logic                   ld_dot,
  input  logic                   ld_line,
  input  logic                   code_ack,
  output logic [MAX_SYMBOLS-1:0] symbol_code,
  output logic [2:0]             symbol_len,
  output logic                   code_valid,
  output logic                   word_space,
  output logic                   overflow_err,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_TICKS);
  localparam logic [CNT_W-1:0] GAP_MAX = '1;
  localparam logic [2:0]       MAX_L  = 3'(MAX_SYMBOLS);

  logic [1:0]             state;
  logic [MAX_SYMBOLS-1:0] code;
  logic [2:0]             len;
  logic [CNT_W-1:0]       gap_cnt;
  logic                   word_armed;

  logic                   sym;
  logic                   gap_inc;
  logic [CNT_W-1:0]       gap_nxt;
  logic                   gap_hit;
  logic                   word_hit;
  logic [MAX_SYMBOLS-1:0] bit0;
  logic [MAX_SYMBOLS-1:0] bit_new;

  assign sym     = ld_dot | ld_line;
  // Counter saturates: once at GAP_MAX it stops incrementing, so the
  // "reaches" compares below fire only on the incrementing tick.
  assign gap_inc  = !sym && tick_en && (gap_cnt != GAP_MAX);
  assign gap_nxt  = gap_cnt + CNT_W'(1);
  assign gap_hit  = gap_inc && (gap_nxt == GAP_C);
  assign word_hit = gap_inc && (gap_nxt == WORD_C);
  assign bit0     = MAX_SYMBOLS'(ld_line);
  assign bit_new  = bit0 << len;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      code         <= '0;
      len          <= '0;
      gap_cnt      <= '0;
      word_armed   <= 1'b0;
      word_space   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      word_space   <= 1'b0;

      if (sym)          gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_nxt;

      // Word gap is timed independently of the letter FSM.
      if (word_hit && word_armed) begin
        word_space <= 1'b1;
        word_armed <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (sym) begin
            code  <= bit0;
            len   <= 3'd1;
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (sym) begin
            if (len == MAX_L) begin
              overflow_err <= 1'b1;
              code         <= '0;
              len          <= '0;
              word_armed   <= 1'b0;  // a discarded letter must not end a word
              state        <= S_DISCARD;
            end else begin
              code <= code | bit_new;
              len  <= len + 3'd1;
            end
          end else if (gap_hit) begin
            word_armed <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (code_ack) begin
            if (sym) begin
              code  <= bit0;
              len   <= 3'd1;
              state <= S_COLLECT;
            end else begin
              code  <= '0;
              len   <= '0;
              state <= S_IDLE;
            end
          end else if (sym) begin
            overflow_err <= 1'b1;  // symbol dropped, held letter untouched
          end
        end
        default: begin  // S_DISCARD
          if (gap_hit) state <= S_IDLE;
        end
      endcase
    end
  end

  assign symbol_code = code;
  assign symbol_len  = len;
  assign code_valid  = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_morse_letter_controller.sv
module tb_morse_letter_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       ld_dot = 1'b0;
  logic       ld_line = 1'b0;
  logic       code_ack = 1'b0;
  logic [4:0] symbol_code;
  logic [2:0] symbol_len;
  logic       code_valid;
  logic       word_space;
  logic       overflow_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ws_seen, cv_seen, ov_seen;

  morse_letter_controller #(
    .MAX_SYMBOLS(5), .GAP_TICKS(8), .WORD_TICKS(20), .CNT_W(5)
  ) dut (
    .clock(clock), .reset(reset), .tick_en(tick_en),
    .ld_dot(ld_dot), .ld_line(ld_line), .code_ack(code_ack),
    .symbol_code(symbol_code), .symbol_len(symbol_len),
    .code_valid(code_valid), .word_space(word_space),
    .overflow_err(overflow_err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic d, input logic l, input logic t, input logic a);
    ld_dot = d; ld_line = l; tick_en = t; code_ack = a;
    @(posedge clock); #1;
    ld_dot = 0; ld_line = 0; tick_en = 0; code_ack = 0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 0);
      if (word_space)   ws_seen++;
      if (code_valid)   cv_seen++;
      if (overflow_err) ov_seen++;
    end
  endtask

  task automatic clr_seen();
    ws_seen = 0; cv_seen = 0; ov_seen = 0;
  endtask

  initial begin
    // ---- 1: reset, dot / tick / line, close, hold, ack
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_code", symbol_code, 5'b0);
    chk("rst_len", symbol_len, 3'd0);
    chk("rst_valid", code_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ws", word_space, 0);
    chk("rst_ovf", overflow_err, 0);

    step(1, 0, 0, 0);
    chk("t1_busy", busy, 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("t1_len2", symbol_len, 3'd2);
    clr_seen();
    run_ticks(7);
    chk("t1_valid_t7", code_valid, 0);
    run_ticks(1);
    chk("t1_valid_t8", code_valid, 1);
    chk("t1_code", symbol_code, 5'b00010);
    chk("t1_len", symbol_len, 3'd2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t1_hold_valid", code_valid, 1);
      chk("t1_hold_code", symbol_code, 5'b00010);
      chk("t1_hold_len", symbol_len, 3'd2);
    end
    step(0, 0, 0, 1);
    chk("t1_ack_valid", code_valid, 0);
    chk("t1_ack_busy", busy, 0);

    // ---- 2: five lines, then overflow on six dots
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    run_ticks(8);
    chk("t2_valid", code_valid, 1);
    chk("t2_code", symbol_code, 5'b11111);
    chk("t2_len", symbol_len, 3'd5);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("t2_ovf_5th", overflow_err, 0);
    chk("t2_len5", symbol_len, 3'd5);
    step(1, 0, 0, 0);
    chk("t2_ovf_6th", overflow_err, 1);
    chk("t2_ovf_busy", busy, 1);
    chk("t2_ovf_valid", code_valid, 0);
    clr_seen();
    run_ticks(7);
    chk("t2_ovf_once", ov_seen, 0);
    chk("t2_busy_t7", busy, 1);
    run_ticks(1);
    chk("t2_busy_t8", busy, 0);
    chk("t2_no_valid", cv_seen, 0);

    // ---- 3: "E", immediate ack, word gap at tick 20, then silence
    step(1, 0, 0, 0);
    clr_seen();
    run_ticks(8);
    chk("t3_valid", code_valid, 1);
    chk("t3_code", symbol_code, 5'b00000);
    chk("t3_len", symbol_len, 3'd1);
    step(0, 0, 0, 1);
    run_ticks(11);
    chk("t3_ws_none_t19", ws_seen, 0);
    run_ticks(1);
    chk("t3_ws_t20", word_space, 1);
    clr_seen();
    run_ticks(40);
    chk("t3_ws_no_repeat", ws_seen, 0);

    // ---- 4: ack + line in the same cycle starts a new letter
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    run_ticks(8);
    chk("t4_valid", code_valid, 1);
    chk("t4_len2", symbol_len, 3'd2);
    step(0, 1, 0, 1);
    chk("t4_valid_drop", code_valid, 0);
    chk("t4_busy", busy, 1);
    chk("t4_code", symbol_code, 5'b00001);
    chk("t4_len", symbol_len, 3'd1);
    chk("t4_no_ovf", overflow_err, 0);
    run_ticks(8);
    chk("t4_valid2", code_valid, 1);
    chk("t4_code2", symbol_code, 5'b00001);
    step(0, 0, 0, 1);

    // ---- 5: dot dropped in hold; dot+line together is a line
    step(0, 1, 0, 0);
    run_ticks(8);
    step(1, 0, 0, 0);
    chk("t5_ovf", overflow_err, 1);
    chk("t5_valid", code_valid, 1);
    chk("t5_code", symbol_code, 5'b00001);
    chk("t5_len", symbol_len, 3'd1);
    step(0, 0, 0, 0);
    chk("t5_ovf_pulse", overflow_err, 0);
    step(0, 0, 0, 1);
    chk("t5_idle", busy, 0);
    step(1, 1, 0, 0);
    chk("t5_both_code", symbol_code, 5'b00001);
    chk("t5_both_len", symbol_len, 3'd1);
    run_ticks(8);
    chk("t5_both_valid", code_valid, 1);
    step(0, 0, 0, 1);

    // ---- 6: reset mid-letter
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t6_code3", symbol_code, 5'b00101);
    run_ticks(4);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_code", symbol_code, 5'b0);
    chk("t6_rst_len", symbol_len, 3'd0);
    chk("t6_rst_valid", code_valid, 0);
    chk("t6_rst_ovf", overflow_err, 0);
    clr_seen();
    run_ticks(30);
    chk("t6_no_valid", cv_seen, 0);
    chk("t6_no_ws", ws_seen, 0);
    chk("t6_no_ovf", ov_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
